ser_ctrl_decoder: RTL and testbench
===================================

# ser_ctrl_decoder

Serial command decoder directly upstream of the 4-lane register-write stage. It receives framed commands on a single-bit serial input qualified by a valid strobe, and checks even parity. Good frames produce a one-cycle lane-enable pulse (`ctrl`) and a data bit (`dout`) in the form the register-write stage samples on `posedge clk`. Bad or stalled frames are dropped and reported.

## Interface
- `TIMEOUT`, 16 — consecutive stalled cycles (`sdi_valid`=0) tolerated mid-frame before abort; legal range 2..255.
- `CNT_W`, 8 — width of good-frame counter.

- `clk`  in  1  — sole clock, rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `sdi`  in  1  — serial command bit.
- `sdi_valid`  in  1  — `sdi` qualifier, sampled each `posedge clk`.
- `ctrl`  out  4  — lane write enables, one-cycle pulse, feeds register-write `ctrl`.
- `dout`  out  1  — write data bit, feeds register-write `in`; valid while `ctrl`≠0.
- `busy`  out  1  — high in any state other than IDLE.
- `err`  out  1  — one-cycle error pulse.
- `err_code`  out  2  — 2'b01 parity, 2'b10 timeout; held until next `err`.
- `frame_cnt`  out  CNT_W  — count of good frames, saturating.

## Operation
- Frame, in order: start(1), op, a1, a0, d, p. That is 1 start bit plus 5 payload bits; only `sdi_valid`=1 cycles carry bits.
- Even parity: op^a1^a0^d^p must be 0.
- op=0: `ctrl` = one-hot(a1a0), bit index = {a1,a0}.
- op=1: broadcast, `ctrl` = 4'b1111; a1a0 are ignored but still covered by parity.
- States:
  - IDLE: `sdi_valid`&&`sdi`=1 → RECV with bit_cnt=0. `sdi_valid`&&`sdi`=0 is ignored.
  - RECV: each valid bit is shifted into a 5-bit payload register, bit_cnt+1. On the 5th bit:
    - parity good → issue outputs, `frame_cnt`+1, → IDLE.
    - parity bad → `err`, code 01, → FLUSH.
  - RECV stall: every `sdi_valid`=0 cycle increments stall_cnt; a valid bit clears it. When stall_cnt reaches `TIMEOUT` → `err`, code 10, → IDLE, payload discarded.
  - FLUSH: ignore input until one cycle with `sdi_valid`=0, then → IDLE.
- `frame_cnt` saturates at 2^CNT_W−1.
- Reset values: `ctrl`=0, `dout`=0, `busy`=0, `err`=0, `err_code`=0, `frame_cnt`=0. State=IDLE, bit_cnt=0, stall_cnt=0.
- Reset mid-frame discards the partial frame; no `ctrl` pulse is emitted after `rst_n` deasserts.

## Timing
- All outputs are registered.
- `ctrl`/`dout` assert in the cycle after the edge that samples p, for exactly 1 cycle. Latency: p sampled at edge N → `ctrl` high between edge N and N+1.
- `err` follows the same rule: high for 1 cycle after the detecting edge.
- Back-to-back frames: a start bit is accepted on the edge immediately following p (FSM is in IDLE). Zero bubble is required.
- `busy` rises the cycle after the start bit edge and falls together with the `ctrl`/`err` pulse.
- Timeout: with the last valid bit at edge N and `sdi_valid`=0 from then on, `err` is high after edge N+`TIMEOUT`.
- A valid bit arriving on the same edge stall_cnt would reach `TIMEOUT`: the bit wins, stall_cnt clears, no error.
- `rst_n` asserts asynchronously and clears all outputs immediately. Deassertion is synchronised externally.

## Structure
- Package `ser_ctrl_pkg`:
  - state enum {IDLE, RECV, FLUSH}
  - constants `ERR_PARITY`=2'b01, `ERR_TIMEOUT`=2'b10, `PAYLOAD_BITS`=5
  - lane-count constant 4
- Sub-module `stall_timer`: counter with clear, enable and `TIMEOUT` compare; outputs `expired`. Everything else lives in `ser_ctrl_decoder`.

## Test plan
- Frame 1,0,1,0,1,0 (lane 2, data 1, parity 0) → `ctrl`=4'b0100, `dout`=1 for one cycle; `frame_cnt`=1.
- Frame 1,1,0,0,0,1 (broadcast, data 0) → `ctrl`=4'b1111, `dout`=0; `frame_cnt`+1.
- Frame 1,0,0,1,1,1 (parity bad) → `err`=1 for one cycle, `err_code`=01, `ctrl` stays 0. Valid stream continues until a `sdi_valid`=0 gap, then the next good frame decodes normally.
- Start then 2 bits, then `sdi_valid`=0 for 16 cycles (`TIMEOUT`=16) → `err`, code 10, after the 16th stalled edge. The 15-cycle variant instead completes the frame.
- Two good frames back-to-back with no gap → two `ctrl` pulses exactly 6 cycles apart.
- `rst_n` low for 1 cycle after the 3rd frame bit → all outputs 0. A subsequent complete frame decodes. 256 good frames with `CNT_W`=8 → `frame_cnt` holds at 255.

Source files
------------

// File: rtl/ser_ctrl_decoder_pkg.sv
// ============================================================================
// Module   : ser_ctrl_pkg
// Purpose  : Shared types and constants for the serial command decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ser_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0]  ERR_PARITY   = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;
  localparam int unsigned PAYLOAD_BITS = 5;
  localparam int unsigned LANES        = 4;

  function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] idx);
    lane_onehot      = '0;
    lane_onehot[idx] = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ser_ctrl_decoder_if.sv
// ============================================================================
// Module   : ser_ctrl_decoder_if
// Purpose  : Serial command input and register-write side outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ser_ctrl_decoder_if
  import ser_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);
  logic             sdi;
  logic             sdi_valid;
  logic [LANES-1:0] ctrl;
  logic             dout;
  logic             busy;
  logic             err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output sdi, sdi_valid,
    input  ctrl, dout, busy, err, err_code, frame_cnt
  );

  modport slave (
    input  sdi, sdi_valid,
    output ctrl, dout, busy, err, err_code, frame_cnt
  );
endinterface

`default_nettype wire

// File: rtl/ser_ctrl_decoder_stall_timer.sv
// ============================================================================
// Module   : stall_timer
// Purpose  : Counts consecutive stalled cycles; flags the TIMEOUT-th one.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr,
  input  wire logic en,
  output logic      expired
);
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (en)  r_cnt <= r_cnt + 8'd1;
  end

  // Fires on the stall that would bring the count to TIMEOUT; a clear wins.
  assign expired = en && !clr && (r_cnt == 8'(TIMEOUT - 1));
endmodule

`default_nettype wire

// File: rtl/ser_ctrl_decoder.sv
// ============================================================================
// Module   : ser_ctrl_decoder
// Purpose  : Framed serial command decoder with even parity and stall abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ser_ctrl_decoder
  import ser_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input wire logic            clk,
  input wire logic            rst_n,
  ser_ctrl_decoder_if.slave   bus
);
  state_t                  r_state, w_state_nxt;
  logic [2:0]              r_bit_cnt, w_bit_cnt_nxt;
  logic [PAYLOAD_BITS-2:0] r_sh, w_sh_nxt;
  logic [LANES-1:0]        r_ctrl, w_ctrl_nxt;
  logic                    r_dout, w_dout_nxt;
  logic                    r_err, w_err_nxt;
  logic [1:0]              r_err_code, w_err_code_nxt;
  logic [CNT_W-1:0]        r_frame_cnt, w_frame_cnt_nxt;
  logic                    w_stall_en, w_stall_clr, w_expired;

  assign w_stall_en  = (r_state == RECV) && !bus.sdi_valid;
  assign w_stall_clr = (r_state != RECV) || bus.sdi_valid;

  stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (w_stall_clr),
    .en      (w_stall_en),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_sh        <= '0;
      r_ctrl      <= '0;
      r_dout      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_sh        <= w_sh_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_dout      <= w_dout_nxt;
      r_err       <= w_err_nxt;
      r_err_code  <= w_err_code_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_sh_nxt        = r_sh;
    w_ctrl_nxt      = '0;
    w_dout_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_err_code_nxt  = r_err_code;
    w_frame_cnt_nxt = r_frame_cnt;
    case (r_state)
      IDLE: begin
        if (bus.sdi_valid && bus.sdi) begin
          w_state_nxt   = RECV;
          w_bit_cnt_nxt = '0;
        end
      end
      RECV: begin
        if (bus.sdi_valid) begin
          w_sh_nxt      = {r_sh[PAYLOAD_BITS-3:0], bus.sdi};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'(PAYLOAD_BITS - 1)) begin
            w_bit_cnt_nxt = '0;
            // r_sh holds {op, a1, a0, d}; the live bit is parity.
            if (^{r_sh, bus.sdi} == 1'b0) begin
              w_state_nxt = IDLE;
              w_ctrl_nxt  = r_sh[3] ? {LANES{1'b1}} : lane_onehot(r_sh[2:1]);
              w_dout_nxt  = r_sh[0];
              if (r_frame_cnt != {CNT_W{1'b1}})
                w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
            end else begin
              w_state_nxt    = FLUSH;
              w_err_nxt      = 1'b1;
              w_err_code_nxt = ERR_PARITY;
            end
          end
        end else if (w_expired) begin
          w_state_nxt    = IDLE;
          w_bit_cnt_nxt  = '0;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      FLUSH: begin
        if (!bus.sdi_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ctrl      = r_ctrl;
  assign bus.dout      = r_dout;
  assign bus.busy      = (r_state != IDLE);
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;
  assign bus.frame_cnt = r_frame_cnt;
endmodule

`default_nettype wire

// File: tb/tb_ser_ctrl_decoder.sv
// ============================================================================
// Module   : tb_ser_ctrl_decoder
// Purpose  : Directed and randomized frames checked against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ser_ctrl_decoder;
  import ser_ctrl_pkg::*;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ser_ctrl_decoder_if #(.CNT_W(CNT_W)) bus ();

  ser_ctrl_decoder #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: collected bits of the current frame plus mode flags.
  bit       m_in_frame, m_flush;
  bit       m_bits[$];
  int       m_stall;
  logic [3:0] m_ctrl;
  logic     m_dout, m_err;
  logic [1:0] m_code;
  int       m_cnt;

  int cycle = 0;
  int last_ctrl_cycle = 0;
  int ctrl_gap = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
  endtask

  task automatic model_reset();
    m_in_frame = 0; m_flush = 0; m_bits.delete(); m_stall = 0;
    m_ctrl = '0; m_dout = 0; m_err = 0; m_code = '0; m_cnt = 0;
  endtask

  task automatic model_step(bit v, bit d);
    int par;
    m_ctrl = '0; m_dout = 0; m_err = 0;
    if (m_flush) begin
      if (!v) m_flush = 0;
    end else if (m_in_frame) begin
      if (v) begin
        m_bits.push_back(d);
        m_stall = 0;
        if (m_bits.size() == 5) begin
          par = m_bits[0] ^ m_bits[1] ^ m_bits[2] ^ m_bits[3] ^ m_bits[4];
          m_in_frame = 0;
          if (par == 0) begin
            m_ctrl = m_bits[0] ? 4'hF : 4'(1 << (m_bits[1] * 2 + m_bits[2]));
            m_dout = m_bits[3];
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
          end else begin
            m_err = 1; m_code = 2'b01; m_flush = 1;
          end
        end
      end else begin
        m_stall++;
        if (m_stall == TIMEOUT) begin
          m_err = 1; m_code = 2'b10; m_in_frame = 0;
        end
      end
    end else if (v && d) begin
      m_in_frame = 1; m_bits.delete(); m_stall = 0;
    end
  endtask

  task automatic compare_all();
    check_eq("ctrl",      32'(bus.ctrl),      32'(m_ctrl));
    check_eq("dout",      32'(bus.dout),      32'(m_dout));
    check_eq("err",       32'(bus.err),       32'(m_err));
    check_eq("err_code",  32'(bus.err_code),  32'(m_code));
    check_eq("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
    check_eq("busy",      32'(bus.busy),      32'(m_in_frame || m_flush));
  endtask

  task automatic tick(bit v, bit d);
    bus.sdi_valid = v;
    bus.sdi       = d;
    @(posedge clk);
    cycle++;
    model_step(v, d);
    #1;
    compare_all();
    if (bus.ctrl != 0) begin
      ctrl_gap        = cycle - last_ctrl_cycle;
      last_ctrl_cycle = cycle;
    end
  endtask

  task automatic idle(int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic send_frame(logic [5:0] f);
    for (int i = 5; i >= 0; i--) tick(1'b1, f[i]);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.sdi = 1'b0;
    bus.sdi_valid = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed test plan
    send_frame(6'b101010); idle(2);
    send_frame(6'b110001); idle(2);
    send_frame(6'b100111);
    send_frame(6'b101010);          // swallowed while flushing
    idle(1);
    send_frame(6'b101010); idle(2);

    tick(1, 1); tick(1, 0); tick(1, 1);
    idle(TIMEOUT); idle(2);

    tick(1, 1); tick(1, 0); tick(1, 0);
    idle(TIMEOUT - 1);
    tick(1, 1); tick(1, 1); tick(1, 0);
    idle(2);

    send_frame(6'b101010);
    send_frame(6'b110001);
    check_eq("b2b_gap", 32'(ctrl_gap), 32'd6);
    idle(2);

    // Asynchronous reset in the middle of a frame
    tick(1, 1); tick(1, 0); tick(1, 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    send_frame(6'b101010); idle(2);

    // Randomized frames with stalls near the timeout boundary and parity errors
    repeat (120) begin
      logic [5:0] f;
      logic [3:0] pl;
      int s;
      pl = 4'($urandom);
      f  = {1'b1, pl, ^pl ^ ($urandom_range(0, 5) == 0)};
      for (int i = 5; i >= 0; i--) begin
        if ($urandom_range(0, 7) == 0) begin
          s = ($urandom_range(0, 3) == 0) ? int'(TIMEOUT) - 2 + int'($urandom_range(0, 3))
                                          : int'($urandom_range(1, 3));
          idle(s);
        end
        tick(1'b1, f[i]);
      end
      idle(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) tick(1'b1, 1'b0);
    end

    // Saturation of the good-frame counter
    repeat (260) send_frame(6'b101010);
    check_eq("frame_cnt_sat", 32'(bus.frame_cnt), 32'd255);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
